// File: rtl/eth_irq_gateway.sv
// Claim/complete interrupt gateway for the Ethernet controller's RX and TX pending levels.
// Each source runs its own IDLE/PENDING/IN_SERVICE/COOLDOWN FSM; claims and completions are arbitrated here.
module eth_irq_gateway #(
    parameter bit          rx_first_p      = 1'b1,
    parameter int unsigned settle_cycles_p = 2
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       rx_pending_i,
    input  logic       tx_pending_i,
    input  logic       irq_enable_i,
    input  logic       claim_v_i,
    output logic [1:0] claim_id_o,
    output logic       claim_id_v_o,
    input  logic       complete_v_i,
    input  logic [1:0] complete_id_i,
    output logic       complete_err_o,
    output logic       irq_o,
    output logic       rx_pop_o,
    output logic       tx_interrupt_clear_o
);

    typedef enum logic [1:0] {
        StIdle,
        StPending,
        StInService,
        StCooldown
    } src_state_e;

    localparam logic [3:0] SettleLoad = 4'(settle_cycles_p);
    localparam int unsigned SrcRx = 0;
    localparam int unsigned SrcTx = 1;

    src_state_e state_q [2];
    src_state_e state_d [2];
    logic [3:0] cnt_q   [2];
    logic [3:0] cnt_d   [2];

    logic [1:0] level;
    logic [1:0] is_pending;
    logic [1:0] sel;
    logic [1:0] cpl;

    logic [1:0] claim_id_d;
    logic       claim_id_v_d;
    logic       complete_err_d;
    logic       rx_pop_d;
    logic       tx_clear_d;

    assign level = {tx_pending_i, rx_pending_i};

    // Arbitration and completion matching use the state before the edge, so a source
    // being completed this cycle is never visible to the claim.
    always_comb begin
        is_pending[SrcRx] = (state_q[SrcRx] == StPending);
        is_pending[SrcTx] = (state_q[SrcTx] == StPending);

        sel[SrcRx] = claim_v_i && is_pending[SrcRx] && (rx_first_p || !is_pending[SrcTx]);
        sel[SrcTx] = claim_v_i && is_pending[SrcTx] && (!rx_first_p || !is_pending[SrcRx]);

        cpl[SrcRx] = complete_v_i && (complete_id_i == 2'd1) &&
                     (state_q[SrcRx] == StInService);
        cpl[SrcTx] = complete_v_i && (complete_id_i == 2'd2) &&
                     (state_q[SrcTx] == StInService);

        claim_id_v_d   = claim_v_i;
        claim_id_d     = sel[SrcRx] ? 2'd1 : (sel[SrcTx] ? 2'd2 : 2'd0);
        complete_err_d = complete_v_i && !cpl[SrcRx] && !cpl[SrcTx];
        rx_pop_d       = cpl[SrcRx];
        tx_clear_d     = cpl[SrcTx];
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (level[i]) begin
                        state_d[i] = StPending;
                    end
                end
                StPending: begin
                    if (sel[i]) begin
                        state_d[i] = StInService;
                    end else if (!level[i]) begin
                        state_d[i] = StIdle;
                    end
                end
                StInService: begin
                    if (cpl[i]) begin
                        state_d[i] = StCooldown;
                        cnt_d[i]   = SettleLoad;
                    end
                end
                StCooldown: begin
                    if (cnt_q[i] <= 4'd1) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = 4'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 4'd1;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            claim_id_o           <= 2'd0;
            claim_id_v_o         <= 1'b0;
            complete_err_o       <= 1'b0;
            rx_pop_o             <= 1'b0;
            tx_interrupt_clear_o <= 1'b0;
        end else begin
            claim_id_o           <= claim_id_d;
            claim_id_v_o         <= claim_id_v_d;
            complete_err_o       <= complete_err_d;
            rx_pop_o             <= rx_pop_d;
            tx_interrupt_clear_o <= tx_clear_d;
        end
    end

    // Only the PENDING state raises the line; IN_SERVICE and COOLDOWN keep it low.
    assign irq_o = irq_enable_i && (is_pending[SrcRx] || is_pending[SrcTx]);

endmodule

// File: tb/tb_eth_irq_gateway.sv
// Directed, table-driven bench for eth_irq_gateway (rx_first_p = 1, settle_cycles_p = 2).
// Vectors run back to back from reset; async reset is exercised in a hand-written sequence.
module tb_eth_irq_gateway;

    logic       clk;
    logic       reset_n;
    logic       rx_pending;
    logic       tx_pending;
    logic       irq_enable;
    logic       claim_v;
    logic [1:0] claim_id;
    logic       claim_id_v;
    logic       complete_v;
    logic [1:0] complete_id;
    logic       complete_err;
    logic       irq;
    logic       rx_pop;
    logic       tx_clear;

    int n_cmp = 0;
    int n_bad = 0;

    eth_irq_gateway #(
        .rx_first_p     (1'b1),
        .settle_cycles_p(2)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .rx_pending_i        (rx_pending),
        .tx_pending_i        (tx_pending),
        .irq_enable_i        (irq_enable),
        .claim_v_i           (claim_v),
        .claim_id_o          (claim_id),
        .claim_id_v_o        (claim_id_v),
        .complete_v_i        (complete_v),
        .complete_id_i       (complete_id),
        .complete_err_o      (complete_err),
        .irq_o               (irq),
        .rx_pop_o            (rx_pop),
        .tx_interrupt_clear_o(tx_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rx;
        logic       tx;
        logic       en;
        logic       clm;
        logic       cv;
        logic [1:0] cid;
        logic [1:0] e_id;
        logic       e_v;
        logic       e_err;
        logic       e_irq;
        logic       e_pop;
        logic       e_clr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int rx, input int tx, input int en, input int clm, input int cv,
                       input int cid, input int e_id, input int e_v, input int e_err,
                       input int e_irq, input int e_pop, input int e_clr);
        vec_t v;
        v.rx = 1'(rx); v.tx = 1'(tx); v.en = 1'(en); v.clm = 1'(clm); v.cv = 1'(cv);
        v.cid = 2'(cid); v.e_id = 2'(e_id); v.e_v = 1'(e_v); v.e_err = 1'(e_err);
        v.e_irq = 1'(e_irq); v.e_pop = 1'(e_pop); v.e_clr = 1'(e_clr);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [1:0] act,
                         input logic [1:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp_v);
        end
    endtask

    task automatic check_all(input int idx, input logic [1:0] e_id, input logic e_v,
                             input logic e_err, input logic e_irq, input logic e_pop,
                             input logic e_clr);
        check("claim_id", idx, claim_id, e_id);
        check("claim_id_v", idx, {1'b0, claim_id_v}, {1'b0, e_v});
        check("complete_err", idx, {1'b0, complete_err}, {1'b0, e_err});
        check("irq", idx, {1'b0, irq}, {1'b0, e_irq});
        check("rx_pop", idx, {1'b0, rx_pop}, {1'b0, e_pop});
        check("tx_clear", idx, {1'b0, tx_clear}, {1'b0, e_clr});
    endtask

    task automatic drive(input logic rx, input logic tx, input logic en, input logic clm,
                         input logic cv, input logic [1:0] cid);
        rx_pending = rx; tx_pending = tx; irq_enable = en;
        claim_v = clm; complete_v = cv; complete_id = cid;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        reset_n = 1'b0;

        //  rx tx en clm cv cid | id v err irq pop clr
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 0 idle
        add(1, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0);  // 1 RX pending -> irq
        add(1, 0, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0);  // 2 claim RX
        add(1, 0, 1, 0, 1, 1,   0, 0, 0, 0, 1, 0);  // 3 complete RX (M)
        add(1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 4 cooldown
        add(1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 5 cooldown ends
        add(1, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0);  // 6 RX re-armed
        add(1, 1, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0);  // 7 both pending
        add(1, 1, 1, 1, 0, 0,   1, 1, 0, 1, 0, 0);  // 8 claim -> RX first
        add(1, 1, 1, 1, 0, 0,   2, 1, 0, 0, 0, 0);  // 9 claim -> TX
        add(1, 1, 1, 1, 0, 0,   0, 1, 0, 0, 0, 0);  // 10 claim -> none
        add(0, 1, 1, 0, 1, 2,   0, 0, 0, 0, 0, 1);  // 11 complete TX
        add(0, 1, 1, 0, 1, 1,   0, 0, 0, 0, 1, 0);  // 12 complete RX
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 13
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 14 both idle
        add(0, 0, 1, 0, 1, 2,   0, 0, 1, 0, 0, 0);  // 15 complete TX while idle
        add(0, 0, 1, 0, 1, 3,   0, 0, 1, 0, 0, 0);  // 16 complete id 3
        add(0, 0, 1, 0, 1, 0,   0, 0, 1, 0, 0, 0);  // 17 complete id 0
        add(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 18 TX pending, masked
        add(0, 1, 0, 1, 0, 0,   2, 1, 0, 0, 0, 0);  // 19 masked claim -> TX
        add(0, 1, 0, 0, 1, 2,   0, 0, 0, 0, 0, 1);  // 20 complete TX
        add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 21
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 22 TX idle
        add(0, 1, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0);  // 23 TX one-cycle pulse
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 24 level drop -> idle
        add(0, 0, 1, 1, 0, 0,   0, 1, 0, 0, 0, 0);  // 25 claim -> none
        add(1, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0);  // 26 RX pending
        add(1, 0, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0);  // 27 claim RX
        add(0, 1, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0);  // 28 TX pending, RX in service
        add(0, 1, 1, 1, 1, 1,   2, 1, 0, 0, 1, 0);  // 29 claim + complete RX
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 30
        add(0, 0, 1, 0, 1, 1,   0, 0, 1, 0, 0, 0);  // 31 complete RX in cooldown
        add(0, 0, 1, 0, 1, 2,   0, 0, 0, 0, 0, 1);  // 32 complete TX
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 33
        add(0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);  // 34

        repeat (2) @(posedge clk);
        #1;
        check_all(-1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].rx, vecs[i].tx, vecs[i].en, vecs[i].clm, vecs[i].cv, vecs[i].cid);
            @(posedge clk);
            #1;
            check_all(i, vecs[i].e_id, vecs[i].e_v, vecs[i].e_err, vecs[i].e_irq,
                      vecs[i].e_pop, vecs[i].e_clr);
        end

        // Async reset while RX is IN_SERVICE with a claim response showing and a complete queued.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        check_all(100, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all(101, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all(102, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_all(103 + k, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Both FSMs idle: completing RX errors, both levels arm, claims return 1 then 2.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
        @(posedge clk);
        #1;
        check_all(110, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        check_all(111, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        check_all(112, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all(113, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
